rcservo_multi: RTL and testbench

RCSERVO_MULTI -- requirements
Module: rcservo_multi

---
 rtl/rcservo_pkg.sv | 12 +
 rtl/rcservo_channel.sv | 54 +++++
 rtl/rcservo_multi.sv | 57 +++++
 tb/tb_rcservo_multi.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rcservo_pkg.sv
// rcservo_pkg: tick conversion and pulse clamp helpers shared by the RC servo cores.
package rcservo_pkg;
    localparam int US_PER_S = 1_000_000;
    // Wide enough that center + any 32-bit signed offset never wraps.
    typedef logic signed [33:0] tick_t;
    function automatic int us_to_ticks(input int clk_freq, input int us);
        return (clk_freq / US_PER_S) * us;
    endfunction
    function automatic tick_t clamp_ticks(input tick_t v, input tick_t lo, input tick_t hi);
        return v < lo ? lo : (v > hi ? hi : v);
    endfunction
endpackage

// File: rtl/rcservo_channel.sv
// rcservo_channel: one servo lane; clamps and slews the frame-sampled command and drives the pulse.
module rcservo_channel
    import rcservo_pkg::*;
#(
    parameter int MIN_T    = 1000,
    parameter int CENTER_T = 1500,
    parameter int MAX_T    = 2000,
    parameter int SLEW_T   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_sample,
    input  logic               i_en,
    input  logic signed [31:0] i_cmd,
    input  logic [31:0]        i_cnt,
    output logic               o_pwm,
    output logic signed [31:0] o_fb
);
    logic               r_en;
    logic               r_pwm;
    tick_t              r_width;
    logic signed [31:0] r_fb;
    tick_t              w_target;
    tick_t              w_diff;
    tick_t              w_next;

    always_comb begin
        w_target = clamp_ticks(tick_t'(CENTER_T) + tick_t'(i_cmd), tick_t'(MIN_T), tick_t'(MAX_T));
        w_diff   = w_target - r_width;
        w_next   = SLEW_T == 0 ? w_target :
                   w_diff > tick_t'(SLEW_T)  ? r_width + tick_t'(SLEW_T) :
                   w_diff < -tick_t'(SLEW_T) ? r_width - tick_t'(SLEW_T) : w_target;
    end

    // Pulse is registered, so comparing against the current count lands it on cycles 1..width.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en    <= 1'b0;
            r_pwm   <= 1'b0;
            r_width <= tick_t'(CENTER_T);
            r_fb    <= '0;
        end else begin
            r_pwm <= r_en && tick_t'(i_cnt) < r_width;
            if (i_sample) begin
                r_en    <= i_en;
                r_width <= i_en ? w_next : tick_t'(CENTER_T);
                r_fb    <= i_en ? 32'(w_next - tick_t'(CENTER_T)) : '0;
            end
        end
    end

    assign o_pwm = r_pwm;
    assign o_fb  = r_fb;
endmodule

// File: rtl/rcservo_multi.sv
// rcservo_multi: CHANNELS independent RC servo PWM outputs sharing one frame counter.
module rcservo_multi
    import rcservo_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int CLK_FREQ  = 50_000_000,
    parameter int FRAME_US  = 20000,
    parameter int MIN_US    = 1000,
    parameter int CENTER_US = 1500,
    parameter int MAX_US    = 2000,
    parameter int SLEW_US   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS*32-1:0] jointFreqCmd,
    input  logic [CHANNELS-1:0]    jointEnable,
    output logic [CHANNELS*32-1:0] jointFeedback,
    output logic [CHANNELS-1:0]    PWM,
    output logic                   frame_start
);
    localparam int FRAME_T  = us_to_ticks(CLK_FREQ, FRAME_US);
    localparam int MIN_T    = us_to_ticks(CLK_FREQ, MIN_US);
    localparam int CENTER_T = us_to_ticks(CLK_FREQ, CENTER_US);
    localparam int MAX_T    = us_to_ticks(CLK_FREQ, MAX_US);
    localparam int SLEW_T   = us_to_ticks(CLK_FREQ, SLEW_US);
    localparam int CNT_W    = $clog2(FRAME_T);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = r_cnt == CNT_W'(FRAME_T - 1);

    always_ff @(posedge clk) begin
        r_cnt <= rst || w_last ? '0 : r_cnt + 1'b1;
    end

    // Gated by rst so the held-at-zero counter does not flag frames during reset.
    assign frame_start = r_cnt == '0 && !rst;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        rcservo_channel #(
            .MIN_T   (MIN_T),
            .CENTER_T(CENTER_T),
            .MAX_T   (MAX_T),
            .SLEW_T  (SLEW_T)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .i_sample(w_last),
            .i_en    (jointEnable[c]),
            .i_cmd   (jointFreqCmd[32*c +: 32]),
            .i_cnt   (32'(r_cnt)),
            .o_pwm   (PWM[c]),
            .o_fb    (jointFeedback[32*c +: 32])
        );
    end
endmodule

// File: tb/tb_rcservo_multi.sv
// tb_rcservo_multi: frame-level check of two rcservo_multi builds (no slew / 100-tick slew) against a width model.
module tb_rcservo_multi;
    localparam int FT = 3000;
    localparam int C  = 1500;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] cmd = '0;
    logic [1:0]  en  = '0;
    logic [63:0] fb_a, fb_b;
    logic [1:0]  pwm_a, pwm_b;
    logic        fs_a, fs_b;

    int n_chk = 0;
    int n_err = 0;
    int m_cnt = 0;
    int m_w[4], a_w[4], hi[4], first[4], last[4];
    bit m_en[4], a_en[4];
    int fs_n[2], fs_pos[2];
    bit have_frame = 1'b0;

    always #5 clk = ~clk;

    rcservo_multi #(.CHANNELS(2), .CLK_FREQ(1_000_000), .FRAME_US(FT)) dut_a (
        .clk(clk), .rst(rst), .jointFreqCmd(cmd), .jointEnable(en),
        .jointFeedback(fb_a), .PWM(pwm_a), .frame_start(fs_a)
    );

    rcservo_multi #(.CHANNELS(2), .CLK_FREQ(1_000_000), .FRAME_US(FT), .SLEW_US(100)) dut_b (
        .clk(clk), .rst(rst), .jointFreqCmd(cmd), .jointEnable(en),
        .jointFeedback(fb_b), .PWM(pwm_b), .frame_start(fs_b)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic int next_w(input int w, input int c, input bit e, input int s);
        longint t;
        longint d;
        if (!e) return C;
        t = longint'(C) + longint'(c);
        t = t < 1000 ? 1000 : (t > 2000 ? 2000 : t);
        d = t - w;
        if (s != 0) d = d > s ? s : (d < -s ? -s : d);
        return w + int'(d);
    endfunction

    function automatic int cmd_l(input int l);
        logic [31:0] v;
        v = cmd[32*(l%2) +: 32];
        return int'($signed(v));
    endfunction

    function automatic bit pwm_l(input int l);
        return l < 2 ? pwm_a[l] : pwm_b[l-2];
    endfunction

    function automatic int fb_l(input int l);
        logic [31:0] v;
        v = l < 2 ? fb_a[32*l +: 32] : fb_b[32*(l-2) +: 32];
        return int'($signed(v));
    endfunction

    function automatic logic [31:0] rnd_cmd();
        int k;
        k = int'($urandom_range(0, 3));
        if (k == 0) return 32'(int'($urandom_range(0, 1400)) - 700);
        if (k == 1) return $urandom;
        if (k == 2) return $urandom_range(0, 1) != 0 ? 32'h8000_0000 : 32'h7fff_ffff;
        return '0;
    endfunction

    task automatic clear_frame();
        for (int l = 0; l < 4; l++) begin
            hi[l] = 0;
            first[l] = -1;
            last[l] = -1;
        end
        fs_n = '{0, 0};
        fs_pos = '{-1, -1};
    endtask

    task automatic observe();
        if (m_cnt == 0) begin
            if (have_frame) begin
                for (int l = 0; l < 4; l++) begin
                    chk($sformatf("hi%0d", l), hi[l], a_en[l] ? a_w[l] : 0);
                    if (a_en[l]) begin
                        chk($sformatf("rise%0d", l), first[l], 1);
                        chk($sformatf("fall%0d", l), last[l], a_w[l]);
                    end
                end
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("fs_n%0d", d), fs_n[d], 1);
                    chk($sformatf("fs_pos%0d", d), fs_pos[d], 0);
                end
            end
            clear_frame();
            for (int l = 0; l < 4; l++) begin
                a_w[l] = m_w[l];
                a_en[l] = m_en[l];
                chk($sformatf("fb%0d", l), fb_l(l), a_en[l] ? a_w[l] - C : 0);
            end
            have_frame = 1'b1;
        end
        for (int l = 0; l < 4; l++) begin
            if (pwm_l(l)) begin
                if (hi[l] == 0) first[l] = m_cnt;
                last[l] = m_cnt;
                hi[l]++;
            end
        end
        if (fs_a) begin fs_n[0]++; fs_pos[0] = m_cnt; end
        if (fs_b) begin fs_n[1]++; fs_pos[1] = m_cnt; end
    endtask

    task automatic cycle();
        if (rst) begin
            m_cnt = 0;
            for (int l = 0; l < 4; l++) begin
                m_w[l] = C; a_w[l] = C; m_en[l] = 1'b0; a_en[l] = 1'b0;
            end
        end else begin
            if (m_cnt == FT - 1) begin
                for (int l = 0; l < 4; l++) begin
                    m_w[l] = next_w(m_w[l], cmd_l(l), en[l%2], l < 2 ? 0 : 100);
                    m_en[l] = en[l%2];
                end
            end
            m_cnt = (m_cnt + 1) % FT;
        end
        @(negedge clk);
        if (rst) begin
            have_frame = 1'b0;
            chk("rst_pwm", {pwm_b, pwm_a}, 0);
            chk("rst_fb", {fb_b, fb_a} != '0, 0);
            chk("rst_fs", {fs_b, fs_a}, 0);
        end else begin
            observe();
        end
    endtask

    task automatic drop_rst();
        rst = 1'b0;
        #1;
        chk("rel_fs", {fs_b, fs_a}, 3);
        clear_frame();
        fs_n = '{1, 1};
        fs_pos = '{0, 0};
        have_frame = 1'b1;
    endtask

    task automatic run_to(input int c);
        do cycle(); while (m_cnt != c);
    endtask

    initial begin
        repeat (3) cycle();
        drop_rst();
        run_to(10);
        en = 2'b11;
        run_to(10);
        cmd[31:0] = 32'd400;
        repeat (5) run_to(10);
        cmd[31:0] = 32'd128000;
        cmd[63:32] = -32'sd128000;
        run_to(10);
        run_to(500);
        cmd = '0;
        run_to(10);
        en = 2'b10;
        run_to(10);
        en = 2'b11;
        cmd[31:0] = 32'd400;
        run_to(10);
        repeat (8) begin
            run_to(int'($urandom_range(1, FT - 1)));
            en = $urandom_range(0, 3) != 0 ? 2'b11 : 2'(($urandom));
            cmd[31:0] = rnd_cmd();
            cmd[63:32] = rnd_cmd();
        end
        run_to(10);
        en = 2'b11;
        cmd = '0;
        run_to(0);
        run_to(700);
        chk("pre_rst_pwm", {pwm_b, pwm_a}, 15);
        rst = 1'b1;
        repeat (3) cycle();
        drop_rst();
        run_to(0);
        run_to(0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
